scpu_v1: RTL and testbench

SCPU_V1 -- requirements
Module: scpu_v1

---
 rtl/scpu_v1.sv | 198 +++++++++++++++++++
 tb/tb_scpu_v1.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scpu_v1.sv
// Single-cycle MIPS subset core: combinational decode/execute of inst_in,
// PC and register-file commit on the rising clock edge.
module scpu_v1 (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst_in,
    input  logic [31:0] Data_in,
    input  logic [4:0]  test_reg_index,
    output logic        mem_w,
    output logic [31:0] PC_out,
    output logic [31:0] Addr_out,
    output logic [31:0] Data_out,
    output logic [31:0] test_reg_result
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'h00,
        OP_J     = 6'h02,
        OP_JAL   = 6'h03,
        OP_BEQ   = 6'h04,
        OP_BNE   = 6'h05,
        OP_ADDI  = 6'h08,
        OP_SLTI  = 6'h0A,
        OP_ANDI  = 6'h0C,
        OP_ORI   = 6'h0D,
        OP_LUI   = 6'h0F,
        OP_LW    = 6'h23,
        OP_SW    = 6'h2B
    } opcode_e;

    typedef enum logic [5:0] {
        FN_SLL = 6'h00,
        FN_SRL = 6'h02,
        FN_JR  = 6'h08,
        FN_ADD = 6'h20,
        FN_SUB = 6'h22,
        FN_AND = 6'h24,
        FN_OR  = 6'h25,
        FN_NOR = 6'h27,
        FN_SLT = 6'h2A
    } funct_e;

    logic [31:0] r_pc;
    logic [31:0] r_regs [32];

    opcode_e     w_op;
    funct_e      w_fn;
    logic [4:0]  w_rs;
    logic [4:0]  w_rt;
    logic [4:0]  w_rd;
    logic [4:0]  w_sh;
    logic [15:0] w_imm;
    logic [31:0] w_sext;
    logic [31:0] w_zext;
    logic [31:0] w_rs_val;
    logic [31:0] w_rt_val;
    logic [31:0] w_pc4;
    logic [31:0] w_br_tgt;
    logic [31:0] w_j_tgt;
    logic [31:0] w_alu;
    logic [31:0] w_wd;
    logic [4:0]  w_wa;
    logic        w_we;
    logic        w_mem_w;
    logic [31:0] w_next_pc;

    assign w_op     = opcode_e'(inst_in[31:26]);
    assign w_fn     = funct_e'(inst_in[5:0]);
    assign w_rs     = inst_in[25:21];
    assign w_rt     = inst_in[20:16];
    assign w_rd     = inst_in[15:11];
    assign w_sh     = inst_in[10:6];
    assign w_imm    = inst_in[15:0];
    assign w_sext   = {{16{w_imm[15]}}, w_imm};
    assign w_zext   = {16'h0000, w_imm};

    assign w_rs_val = (w_rs == 5'd0) ? '0 : r_regs[w_rs];
    assign w_rt_val = (w_rt == 5'd0) ? '0 : r_regs[w_rt];

    assign w_pc4    = r_pc + 32'd4;
    assign w_br_tgt = w_pc4 + {w_sext[29:0], 2'b00};
    assign w_j_tgt  = {w_pc4[31:28], inst_in[25:0], 2'b00};

    // Decode and execute: ALU result, writeback select, memory strobe, next PC
    always_comb begin
        w_alu     = '0;
        w_wd      = '0;
        w_wa      = '0;
        w_we      = 1'b0;
        w_mem_w   = 1'b0;
        w_next_pc = w_pc4;
        case (w_op)
            OP_RTYPE: begin
                w_wa = w_rd;
                w_we = 1'b1;
                case (w_fn)
                    FN_ADD: w_alu = w_rs_val + w_rt_val;
                    FN_SUB: w_alu = w_rs_val - w_rt_val;
                    FN_AND: w_alu = w_rs_val & w_rt_val;
                    FN_OR:  w_alu = w_rs_val | w_rt_val;
                    FN_NOR: w_alu = ~(w_rs_val | w_rt_val);
                    FN_SLT: w_alu = {31'b0, $signed(w_rs_val) < $signed(w_rt_val)};
                    FN_SLL: w_alu = w_rt_val << w_sh;
                    FN_SRL: w_alu = w_rt_val >> w_sh;
                    FN_JR: begin
                        w_we      = 1'b0;
                        w_next_pc = w_rs_val;
                    end
                    default: w_we = 1'b0;
                endcase
                w_wd = w_alu;
            end
            OP_ADDI: begin
                w_alu = w_rs_val + w_sext;
                w_wa  = w_rt;
                w_we  = 1'b1;
                w_wd  = w_alu;
            end
            OP_SLTI: begin
                w_alu = {31'b0, $signed(w_rs_val) < $signed(w_sext)};
                w_wa  = w_rt;
                w_we  = 1'b1;
                w_wd  = w_alu;
            end
            OP_ANDI: begin
                w_alu = w_rs_val & w_zext;
                w_wa  = w_rt;
                w_we  = 1'b1;
                w_wd  = w_alu;
            end
            OP_ORI: begin
                w_alu = w_rs_val | w_zext;
                w_wa  = w_rt;
                w_we  = 1'b1;
                w_wd  = w_alu;
            end
            OP_LUI: begin
                w_alu = {w_imm, 16'h0000};
                w_wa  = w_rt;
                w_we  = 1'b1;
                w_wd  = w_alu;
            end
            OP_LW: begin
                w_alu = w_rs_val + w_sext;
                w_wa  = w_rt;
                w_we  = 1'b1;
                w_wd  = Data_in;
            end
            OP_SW: begin
                w_alu   = w_rs_val + w_sext;
                w_mem_w = 1'b1;
            end
            OP_BEQ: begin
                w_alu = w_rs_val - w_rt_val;
                if (w_rs_val == w_rt_val) w_next_pc = w_br_tgt;
            end
            OP_BNE: begin
                w_alu = w_rs_val - w_rt_val;
                if (w_rs_val != w_rt_val) w_next_pc = w_br_tgt;
            end
            OP_J: begin
                w_next_pc = w_j_tgt;
            end
            OP_JAL: begin
                w_wa      = 5'd31;
                w_we      = 1'b1;
                w_wd      = w_pc4;
                w_next_pc = w_j_tgt;
            end
            default: begin
                w_alu = '0;
            end
        endcase
    end

    // PC and register-file commit; reset clears all architectural state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
            for (int unsigned i = 0; i < 32; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            r_pc <= w_next_pc;
            if (w_we && (w_wa != 5'd0)) begin
                r_regs[w_wa] <= w_wd;
            end
        end
    end

    // Store strobe is forced low while reset is held, even if inst_in is a SW
    assign mem_w           = w_mem_w & ~reset;
    assign PC_out          = r_pc;
    assign Addr_out        = w_alu;
    assign Data_out        = w_rt_val;
    assign test_reg_result = (test_reg_index == 5'd0) ? '0 : r_regs[test_reg_index];

endmodule

// File: tb/tb_scpu_v1.sv
// Directed and randomized check of scpu_v1 against an instruction-level model.
module tb_scpu_v1;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] inst_in;
    logic [31:0] Data_in;
    logic [4:0]  test_reg_index;
    logic        mem_w;
    logic [31:0] PC_out;
    logic [31:0] Addr_out;
    logic [31:0] Data_out;
    logic [31:0] test_reg_result;

    int total = 0;
    int bad   = 0;

    logic [31:0] m_reg [32];
    logic [31:0] m_pc;

    scpu_v1 dut (
        .clk             (clk),
        .reset           (reset),
        .inst_in         (inst_in),
        .Data_in         (Data_in),
        .test_reg_index  (test_reg_index),
        .mem_w           (mem_w),
        .PC_out          (PC_out),
        .Addr_out        (Addr_out),
        .Data_out        (Data_out),
        .test_reg_result (test_reg_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chkreg(input logic [4:0] idx, input logic [31:0] exp);
        test_reg_index = idx;
        #1;
        chk($sformatf("reg%0d", idx), test_reg_result, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_pc = '0;
    endtask

    // Architectural effect of one instruction, then compare the DUT around one edge
    task automatic step(input logic [31:0] ins, input logic [31:0] din);
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [4:0]  probe;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] se;
        logic [31:0] ze;
        logic [31:0] pc4;
        logic [31:0] npc;
        logic [31:0] wv;
        logic [31:0] ea;
        logic        mw;
        int          wi;
        op  = ins[31:26];
        fn  = ins[5:0];
        rs  = ins[25:21];
        rt  = ins[20:16];
        rd  = ins[15:11];
        sh  = ins[10:6];
        a   = m_reg[rs];
        b   = m_reg[rt];
        se  = 32'($signed(ins[15:0]));
        ze  = {16'h0000, ins[15:0]};
        pc4 = m_pc + 32'd4;
        npc = pc4;
        ea  = a + se;
        wv  = '0;
        wi  = -1;
        mw  = 1'b0;
        case (op)
            6'h00: case (fn)
                6'h20: begin wi = rd; wv = a + b; end
                6'h22: begin wi = rd; wv = a - b; end
                6'h24: begin wi = rd; wv = a & b; end
                6'h25: begin wi = rd; wv = a | b; end
                6'h27: begin wi = rd; wv = ~(a | b); end
                6'h2A: begin wi = rd; wv = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0; end
                6'h00: begin wi = rd; wv = b << sh; end
                6'h02: begin wi = rd; wv = b >> sh; end
                6'h08: npc = a;
                default: ;
            endcase
            6'h08: begin wi = rt; wv = a + se; end
            6'h0A: begin wi = rt; wv = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
            6'h0C: begin wi = rt; wv = a & ze; end
            6'h0D: begin wi = rt; wv = a | ze; end
            6'h0F: begin wi = rt; wv = {ins[15:0], 16'h0000}; end
            6'h23: begin wi = rt; wv = din; end
            6'h2B: mw = 1'b1;
            6'h04: if (a == b) npc = pc4 + (se << 2);
            6'h05: if (a != b) npc = pc4 + (se << 2);
            6'h02: npc = {pc4[31:28], ins[25:0], 2'b00};
            6'h03: begin npc = {pc4[31:28], ins[25:0], 2'b00}; wi = 31; wv = pc4; end
            default: ;
        endcase

        @(negedge clk);
        inst_in        = ins;
        Data_in        = din;
        probe          = 5'($urandom);
        test_reg_index = probe;
        #1;
        chk("mem_w", {31'b0, mem_w}, {31'b0, mw});
        chk("data_out", Data_out, b);
        if (op == 6'h23 || op == 6'h2B) chk("addr_out", Addr_out, ea);
        chk("dbg_read", test_reg_result, m_reg[probe]);

        @(posedge clk);
        #1;
        m_pc = npc;
        if (wi > 0) m_reg[wi] = wv;
        chk("pc", PC_out, m_pc);
        if (wi >= 0) begin
            test_reg_index = 5'(wi);
            #1;
            chk("reg_wr", test_reg_result, m_reg[wi]);
        end
    endtask

    function automatic logic [31:0] rand_inst();
        logic [5:0] fns [9];
        logic [5:0] ops [12];
        int         k;
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h08};
        ops = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
        k = $urandom_range(0, 21);
        if (k < 9)
            return {6'h00, 15'($urandom), 5'($urandom), fns[k]};
        else if (k < 21)
            return {ops[k - 9], 26'($urandom)};
        else
            return {6'h00, 20'($urandom), 6'h3F};
    endfunction

    initial begin
        reset          = 1'b1;
        inst_in        = 32'hAC100004;
        Data_in        = '0;
        test_reg_index = 5'd14;
        model_reset();
        #12;
        chk("rst_pc", PC_out, 32'h0);
        chk("rst_memw", {31'b0, mem_w}, 32'h0);
        chk("rst_reg", test_reg_result, 32'h0);

        @(posedge clk);
        #1;
        reset = 1'b0;

        step(32'h200E8000, 32'h0);
        chkreg(5'd14, 32'hFFFF8000);
        chk("pc_addi", PC_out, 32'h4);

        step(32'h3C09CDCD, 32'h0);
        step(32'h000940C2, 32'h0);
        chkreg(5'd9, 32'hCDCD0000);
        chkreg(5'd8, 32'h19B9A000);

        step(32'h8C100004, 32'hCDCDCDCD);
        chkreg(5'd16, 32'hCDCDCDCD);
        step(32'hAC100004, 32'h12345678);
        chkreg(5'd16, 32'hCDCDCDCD);

        step(32'h08000004, 32'h0);
        chk("pc_j", PC_out, 32'h10);
        step(32'h11EFFFFC, 32'h0);
        chk("pc_beq", PC_out, 32'h4);
        step(32'h08000004, 32'h0);
        step(32'h15EF0005, 32'h0);
        chk("pc_bne", PC_out, 32'h14);
        step(32'h08000004, 32'h0);
        step(32'h0C00000F, 32'h0);
        chk("pc_jal", PC_out, 32'h3C);
        chkreg(5'd31, 32'h14);
        step(32'h03E00008, 32'h0);
        chk("pc_jr", PC_out, 32'h14);

        step(32'h29CD000D, 32'h0);
        chkreg(5'd13, 32'h1);
        step(32'h340BCDCD, 32'h0);
        chkreg(5'd11, 32'h0000CDCD);
        step(32'h316CCDC8, 32'h0);
        chkreg(5'd12, 32'h0000CDC8);
        step(32'h20000005, 32'h0);
        chkreg(5'd0, 32'h0);

        // inst_in changes mid-cycle: outputs follow, no state change until the edge
        @(negedge clk);
        inst_in = 32'hAC100004;
        #1;
        chk("mid_sw_memw", {31'b0, mem_w}, 32'h1);
        chk("mid_sw_addr", Addr_out, 32'h4);
        inst_in = 32'hFC000000;
        #1;
        chk("mid_nop_memw", {31'b0, mem_w}, 32'h0);
        chk("mid_pc_hold", PC_out, m_pc);
        @(posedge clk);
        #1;
        m_pc = m_pc + 32'd4;
        chk("mid_pc", PC_out, m_pc);

        // asynchronous reset between edges aborts the pending addi
        @(negedge clk);
        inst_in        = 32'h20050007;
        test_reg_index = 5'd14;
        reset          = 1'b1;
        #1;
        chk("async_rst_pc", PC_out, 32'h0);
        chk("async_rst_reg", test_reg_result, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        chk("post_rst_pc", PC_out, 32'h0);
        chkreg(5'd5, 32'h0);

        for (int n = 0; n < 400; n++) begin
            step(rand_inst(), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
